sao_lcu_feeder: RTL

SAO_LCU_FEEDER -- requirements
Module: sao_lcu_feeder

---
 rtl/sao_lcu_feeder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sao_lcu_feeder.sv
// sao_lcu_feeder: streams a 128x128 frame from SRAM to an SAO filter in LCU raster order.
// Optional running pixel checksum is built when SAO_FEED_CHKSUM_EN is defined.
module sao_lcu_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  lcu_size_cfg,
    output logic        ram_cen,
    output logic [13:0] ram_a,
    input  logic [7:0]  ram_q,
    output logic [5:0]  prm_idx,
    input  logic [1:0]  prm_type,
    input  logic [4:0]  prm_band_pos,
    input  logic        prm_eo_class,
    input  logic [15:0] prm_offset,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  sao_type,
    output logic [4:0]  sao_band_pos,
    output logic        sao_eo_class,
    output logic [15:0] sao_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    input  logic        busy,
    input  logic        finish,
    output logic        done,
    output logic [15:0] chksum
);

    typedef enum logic [2:0] {IDLE, PRIME, STREAM, WAIT_FIN, DONE} state_t;

    typedef struct packed {
        logic        last;
        logic [1:0]  size;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [1:0]  typ;
        logic [4:0]  band;
        logic        eo;
        logic [15:0] off;
    } meta_t;

    typedef struct packed {
        logic [7:0] pix;
        meta_t      m;
    } ent_t;

    state_t     state;
    logic [1:0] size_q;
    logic [2:0] fx;
    logic [2:0] fy;
    logic [5:0] fr;
    logic [5:0] fc;
    logic       fetch_end;

    meta_t      pend;
    ent_t       skid;
    ent_t       outr;
    ent_t       incoming;
    logic       pend_v;
    logic       skid_v;
    logic       out_v;

    logic [5:0] n_m1;
    logic [2:0] lpr_m1;
    logic [6:0] row_a;
    logic [6:0] col_a;
    logic       last_c;
    logic       last_r;
    logic       last_x;
    logic       last_y;
    logic       streaming;
    logic       acc;
    logic       issue;
    logic       start_ok;
    logic [1:0] occ_next;

    always_comb begin
        unique case (size_q)
            2'd0:    n_m1 = 6'd15;
            2'd1:    n_m1 = 6'd31;
            default: n_m1 = 6'd63;
        endcase
    end

    assign lpr_m1 = 3'd7 >> size_q;
    assign last_c = (fc == n_m1);
    assign last_r = (fr == n_m1);
    assign last_x = (fx == lpr_m1);
    assign last_y = (fy == lpr_m1);

    // Both halves stay below 128, so concatenation equals (row << 7) + col.
    assign row_a = ({4'd0, fy} << (3'd4 + {1'b0, size_q})) + {1'b0, fr};
    assign col_a = ({4'd0, fx} << (3'd4 + {1'b0, size_q})) + {1'b0, fc};
    assign prm_idx = ({3'd0, fy} << (2'd3 - size_q)) + {3'd0, fx};

    assign start_ok  = (state == IDLE) && start && (lcu_size_cfg != 2'd3);
    assign streaming = (state == STREAM);
    assign acc       = out_v && !busy && streaming;

    // Issue only if the read landing next cycle still finds a free slot.
    assign occ_next = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, pend_v} - {1'b0, acc};
    assign issue    = (state == PRIME) ||
                      (streaming && !fetch_end && (occ_next <= 2'd1));

    assign ram_cen = !issue;
    assign ram_a   = issue ? {row_a, col_a} : 14'd0;

    assign incoming = {ram_q, pend};

    assign in_en        = acc;
    assign din          = outr.pix;
    assign sao_type     = outr.m.typ;
    assign sao_band_pos = outr.m.band;
    assign sao_eo_class = outr.m.eo;
    assign sao_offset   = outr.m.off;
    assign lcu_x        = outr.m.x;
    assign lcu_y        = outr.m.y;
    assign lcu_size     = outr.m.size;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE:     if (start_ok) state <= PRIME;
                PRIME:    state <= STREAM;
                STREAM:   if (acc && outr.m.last) state <= WAIT_FIN;
                WAIT_FIN: if (finish) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q    <= 2'd0;
            fx        <= 3'd0;
            fy        <= 3'd0;
            fr        <= 6'd0;
            fc        <= 6'd0;
            fetch_end <= 1'b0;
        end else if (start_ok) begin
            size_q    <= lcu_size_cfg;
            fx        <= 3'd0;
            fy        <= 3'd0;
            fr        <= 6'd0;
            fc        <= 6'd0;
            fetch_end <= 1'b0;
        end else if (issue) begin
            if (!last_c) begin
                fc <= fc + 6'd1;
            end else begin
                fc <= 6'd0;
                if (!last_r) begin
                    fr <= fr + 6'd1;
                end else begin
                    fr <= 6'd0;
                    if (!last_x) begin
                        fx <= fx + 3'd1;
                    end else begin
                        fx <= 3'd0;
                        if (!last_y) fy <= fy + 3'd1;
                        else fetch_end <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= '0;
            skid   <= '0;
            outr   <= '0;
            pend_v <= 1'b0;
            skid_v <= 1'b0;
            out_v  <= 1'b0;
        end else begin
            pend_v <= issue;
            if (issue) begin
                pend <= {last_c & last_r & last_x & last_y, size_q, fx, fy,
                         prm_type, prm_band_pos, prm_eo_class, prm_offset};
            end
            if (!out_v || acc) begin
                if (skid_v) begin
                    outr   <= skid;
                    out_v  <= 1'b1;
                    skid_v <= pend_v;
                    if (pend_v) skid <= incoming;
                end else begin
                    out_v <= pend_v;
                    if (pend_v) outr <= incoming;
                end
            end else if (pend_v) begin
                skid   <= incoming;
                skid_v <= 1'b1;
            end
        end
    end

`ifdef SAO_FEED_CHKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || start_ok) sum_q <= 16'd0;
        else if (acc) sum_q <= sum_q + {8'd0, outr.pix};
    end

    assign chksum = sum_q;
`else
    assign chksum = 16'd0;
`endif

endmodule
